cmp_sar_search: RTL and testbench
=================================

// Module: cmp_sar_search
// PURPOSE
//  Drives the A-side operand of the 2-bit-style magnitude comparator (GE/LE/NE flag outputs) and
//  consumes its three flags to recover an unknown B-side value by successive approximation (SAR).
//  Sits upstream of the comparator: guess -> comparator a; comparator r/g/bl -> ge_i/le_i/ne_i.
//  One search per start pulse; reports the found value, a done pulse and a flag-consistency error.
// PARAMETERS
//  WIDTH   4  operand width of guess/result; must match the comparator width (>=1)
//  SETTLE  1  cycles guess is held stable before the flags are sampled (>=1, covers comparator path)
// PORTS
//  clk      in   1      single clock, all state on rising edge
//  rst_n    in   1      synchronous reset, active low
//  start    in   1      begin a search; accepted only in IDLE
//  ge_i     in   1      comparator "guess >= target" (r)
//  le_i     in   1      comparator "guess <= target" (g)
//  ne_i     in   1      comparator "guess != target" (bl)
//  guess    out  WIDTH  trial value driven to comparator A input (registered)
//  busy     out  1      high in WAIT and EVAL
//  done     out  1      one-cycle pulse when search ends (success or error)
//  result   out  WIDTH  recovered target; valid from done, held until next accepted start
//  err      out  1      set with done when flags inconsistent; held until next accepted start
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge): state=IDLE, guess=0, result=0, busy=0, done=0, err=0, bit idx=WIDTH-1.
//  Reset mid-search aborts immediately; no done pulse is produced for the aborted search.
//  FSM: IDLE -> WAIT -> EVAL -> (WAIT | DONE) -> IDLE.
//   IDLE: start=1 -> guess=1<<(WIDTH-1), k=WIDTH-1, cnt=SETTLE-1, err=0, result=0, go WAIT.
//   WAIT: hold guess; cnt==0 -> EVAL, else cnt--. Lasts exactly SETTLE cycles.
//   EVAL: sample flags once. Valid codes: {ge,le,ne}=110 equal, 101 greater, 011 less.
//    invalid code (any other) -> err=1, result=guess, go DONE.
//    equal   -> result=guess, go DONE (early exit).
//    greater -> clear bit k of guess.  less -> keep bit k.
//    then k==0: result=adjusted guess; if case was less with k==0 (impossible for valid target)
//     err=1; go DONE.  else k--, set new bit k in guess, cnt=SETTLE-1, go WAIT.
//   DONE: done=1 for this cycle only, busy=0, go IDLE. guess holds last value.
//  start while busy or in DONE: ignored, no queueing. start in IDLE same cycle as DONE->IDLE: n/a
//   (DONE always spends one cycle; start accepted from the following IDLE cycle).
//  Latency: start sampled at edge t; each step = SETTLE+1 cycles; done high in cycle
//   t+1+n*(SETTLE+1), n = evaluations (1..WIDTH). Worst case n=WIDTH.
//  Arithmetic: guess/result unsigned WIDTH bits; only single-bit set/clear, no add, no overflow.
//  Flag inputs assumed synchronous to clk; block does not synchronise them.
// TESTING (WIDTH=4, SETTLE=1, bench models comparator combinationally from guess vs target)
//  target=4'b1011, start at t -> guesses 8,12,10,11; equal at 4th eval; done at t+9, result=11, err=0.
//  target=0 -> guesses 8,4,2,1 all greater; done at t+9, result=0, err=0; guess=0 afterward.
//  target=8 -> first eval equal; done at t+3, result=8, busy high exactly cycles t+1..t+2.
//  force {ge,le,ne}=000 on first eval -> done at t+3, err=1, result=8; next start clears err.
//  start pulsed again during busy -> ignored, original search completes unchanged; rst_n=0 mid
//   search -> next cycle guess=0, busy=0, no done; new start then searches target=15 -> result=15.
//  sweep all targets 0..15 with SETTLE=3 -> result==target, err=0, done latency per formula.

Source files
------------

// File: rtl/cmp_sar_search_if.sv
// Bundle of signals between the SAR search engine and its environment.
//
// start       : one-cycle request to begin a search
// ge_i/le_i/ne_i : comparator flags for guess vs. hidden target
// guess       : trial value presented to the comparator A input
// busy/done   : search in progress / one-cycle completion pulse
// result/err  : recovered value and flag-consistency error
//
// Handshake: start is a request with no ready. The engine accepts it only
// while idle (busy=0 and done=0). A start seen at any other time is dropped,
// not queued. done is a single-cycle pulse. result and err are stable from
// done until the next accepted start.
//
// Modports: slave = the search engine, master = whoever drives start and flags.
interface cmp_sar_search_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             ge_i;
  logic             le_i;
  logic             ne_i;
  logic [WIDTH-1:0] guess;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             err;

  modport master (
    output start, ge_i, le_i, ne_i,
    input  guess, busy, done, result, err
  );

  modport slave (
    input  start, ge_i, le_i, ne_i,
    output guess, busy, done, result, err
  );
endinterface

// File: rtl/cmp_sar_search.sv
// Successive-approximation search that recovers a hidden target value.
// It drives trial values into a magnitude comparator and reads back the
// comparator's GE/LE/NE flags.
//
// Ports:
//   clk       : single clock, all state updates on the rising edge
//   rst_n     : synchronous reset, active low
//   bus       : slave side of cmp_sar_search_if (start, flags, guess,
//               busy, done, result, err)
//   dbg_state : current FSM state (IDLE=0, WAIT=1, EVAL=2, DONE=3)
//
// Each step holds guess for SETTLE cycles (WAIT), then samples the flags
// once (EVAL). An equal code ends the search early. Otherwise the trial
// bit is cleared or kept, and the next lower bit is tried.
module cmp_sar_search #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  cmp_sar_search_if.slave  bus,
  output logic [1:0]       dbg_state
);

  localparam int KW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_EVAL = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] guess_q, guess_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic [KW-1:0]    k_q, k_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0] bit_k;
  logic [WIDTH-1:0] adj;
  logic [2:0]       code;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      guess_q  <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      k_q      <= KW'(WIDTH-1);
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      result_q <= result_d;
      err_q    <= err_d;
      k_q      <= k_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    guess_d  = guess_q;
    result_d = result_q;
    err_d    = err_q;
    k_d      = k_q;
    cnt_d    = cnt_q;
    bit_k    = WIDTH'(1) << k_q;
    adj      = guess_q;
    code     = {bus.ge_i, bus.le_i, bus.ne_i};

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          guess_d  = WIDTH'(1) << (WIDTH-1);
          k_d      = KW'(WIDTH-1);
          cnt_d    = CW'(SETTLE-1);
          err_d    = 1'b0;
          result_d = '0;
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        if (cnt_q == '0) state_d = S_EVAL;
        else             cnt_d   = cnt_q - CW'(1);
      end

      S_EVAL: begin
        case (code)
          3'b110: begin
            result_d = guess_q;
            state_d  = S_DONE;
          end
          3'b101, 3'b011: begin
            // Guess above target: the trial bit must be 0. Guess below: keep it.
            adj = (code == 3'b101) ? (guess_q & ~bit_k) : guess_q;
            if (k_q == '0) begin
              guess_d  = adj;
              result_d = adj;
              // Still "less" on the last bit means no target is consistent
              // with the flags seen so far.
              err_d    = (code == 3'b011);
              state_d  = S_DONE;
            end else begin
              guess_d = adj | (bit_k >> 1);
              k_d     = k_q - KW'(1);
              cnt_d   = CW'(SETTLE-1);
              state_d = S_WAIT;
            end
          end
          default: begin
            err_d    = 1'b1;
            result_d = guess_q;
            state_d  = S_DONE;
          end
        endcase
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.guess  = guess_q;
  assign bus.result = result_q;
  assign bus.err    = err_q;
  assign bus.busy   = (state_q == S_WAIT) || (state_q == S_EVAL);
  assign bus.done   = (state_q == S_DONE);
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_cmp_sar_search.sv
module tb_cmp_sar_search;
  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cmp_sar_search_if #(.WIDTH(W)) b1();
  cmp_sar_search_if #(.WIDTH(W)) b2();
  logic [1:0] dbg1, dbg2;

  cmp_sar_search #(.WIDTH(W), .SETTLE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1), .dbg_state(dbg1));
  cmp_sar_search #(.WIDTH(W), .SETTLE(3)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2), .dbg_state(dbg2));

  // Comparator model: flags are a pure function of guess vs. hidden target.
  logic [W-1:0] tgt1 = '0, tgt2 = '0;
  logic         bad1 = 1'b0;
  logic         start1 = 1'b0, start2 = 1'b0;

  assign b1.start = start1;
  assign b1.ge_i  = bad1 ? 1'b0 : (b1.guess >= tgt1);
  assign b1.le_i  = bad1 ? 1'b0 : (b1.guess <= tgt1);
  assign b1.ne_i  = bad1 ? 1'b0 : (b1.guess != tgt1);
  assign b2.start = start2;
  assign b2.ge_i  = (b2.guess >= tgt2);
  assign b2.le_i  = (b2.guess <= tgt2);
  assign b2.ne_i  = (b2.guess != tgt2);

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic         exp_err_q[$];
  int           exp_lat_q[$];
  logic [W-1:0] g_obs[$];

  int checks = 0;
  int passes = 0;

  // Evaluations needed: the search exits on the step that tries the lowest
  // set bit of the target; target 0 needs every bit.
  function automatic int n_evals(input logic [W-1:0] t);
    for (int i = 0; i < W; i++) if (t[i]) return W - i;
    return W;
  endfunction

  // ---------------- driver tasks ----------------
  // Returns at the first falling edge after the accepting rising edge (offset 1).
  task automatic kick(input bit sel, input logic [W-1:0] t, input bit bad);
    @(negedge clk);
    if (sel) begin tgt2 = t; start2 = 1'b1; end
    else begin tgt1 = t; bad1 = bad; start1 = 1'b1; end
    @(negedge clk);
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Samples on falling edges, lat = offset from the accepting edge.
  // Optionally re-pulses start (DUT1) at offsets poke_a / poke_b.
  task automatic wait_done(input bit sel, input int poke_a, input int poke_b,
                           output logic [W-1:0] r, output logic e,
                           output int lat, output int bcnt, output bit to);
    logic d, b;
    logic [W-1:0] g;
    lat = 1; bcnt = 0; to = 1'b0; r = '0; e = 1'b0;
    g_obs.delete();
    forever begin
      d = sel ? b2.done : b1.done;
      b = sel ? b2.busy : b1.busy;
      g = sel ? b2.guess : b1.guess;
      if (!sel) start1 = (lat == poke_a) || (lat == poke_b);
      if (b && (g_obs.size() == 0 || g_obs[$] != g)) g_obs.push_back(g);
      if (d) begin
        r = sel ? b2.result : b1.result;
        e = sel ? b2.err : b1.err;
        return;
      end
      if (b) bcnt++;
      if (lat >= 200) begin to = 1'b1; start1 = 1'b0; return; end
      @(negedge clk);
      lat++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (b1.guess !== 4'd0)  $display("FAIL reset_guess got=%0d exp=0", b1.guess);  else passes++;
    checks++; if (b1.result !== 4'd0) $display("FAIL reset_result got=%0d exp=0", b1.result); else passes++;
    checks++; if ({b1.busy, b1.done, b1.err} !== 3'b000) $display("FAIL reset_flags got=%b exp=000", {b1.busy, b1.done, b1.err}); else passes++;
    checks++; if (dbg1 !== 2'd0 || dbg2 !== 2'd0) $display("FAIL reset_state got=%0d/%0d exp=0/0", dbg1, dbg2); else passes++;
    rst_n = 1'b1;
  endtask

  task automatic test_target11();
    logic [W-1:0] r, er; logic e, ee; int lat, el, bc; bit to;
    exp_q.push_back(4'd11); exp_err_q.push_back(1'b0); exp_lat_q.push_back(1 + n_evals(4'd11) * 2);
    kick(1'b0, 4'd11, 1'b0);
    wait_done(1'b0, -1, -1, r, e, lat, bc, to);
    er = exp_q.pop_front(); ee = exp_err_q.pop_front(); el = exp_lat_q.pop_front();
    checks++; if (to) $display("FAIL t11_timeout got=timeout exp=done"); else passes++;
    checks++; if (r !== er)  $display("FAIL t11_result got=%0d exp=%0d", r, er); else passes++;
    checks++; if (e !== ee)  $display("FAIL t11_err got=%b exp=%b", e, ee); else passes++;
    checks++; if (lat != 9 || lat != el) $display("FAIL t11_latency got=%0d exp=%0d", lat, el); else passes++;
    checks++;
    if (g_obs.size() != 4 || g_obs[0] !== 4'd8 || g_obs[1] !== 4'd12 || g_obs[2] !== 4'd10 || g_obs[3] !== 4'd11)
      $display("FAIL t11_guess_seq got=%p exp=8,12,10,11", g_obs);
    else passes++;
  endtask

  task automatic test_target0();
    logic [W-1:0] r, er; logic e, ee; int lat, el, bc; bit to;
    exp_q.push_back(4'd0); exp_err_q.push_back(1'b0); exp_lat_q.push_back(1 + n_evals(4'd0) * 2);
    kick(1'b0, 4'd0, 1'b0);
    wait_done(1'b0, -1, -1, r, e, lat, bc, to);
    er = exp_q.pop_front(); ee = exp_err_q.pop_front(); el = exp_lat_q.pop_front();
    checks++; if (to || r !== er || e !== ee) $display("FAIL t0_result got=%0d/%b exp=%0d/%b", r, e, er, ee); else passes++;
    checks++; if (lat != el) $display("FAIL t0_latency got=%0d exp=%0d", lat, el); else passes++;
    checks++;
    if (g_obs.size() != 4 || g_obs[0] !== 4'd8 || g_obs[1] !== 4'd4 || g_obs[2] !== 4'd2 || g_obs[3] !== 4'd1)
      $display("FAIL t0_guess_seq got=%p exp=8,4,2,1", g_obs);
    else passes++;
    @(negedge clk);
    checks++; if (b1.guess !== 4'd0) $display("FAIL t0_guess_after got=%0d exp=0", b1.guess); else passes++;
  endtask

  task automatic test_target8();
    logic [W-1:0] r, er; logic e, ee; int lat, el, bc; bit to;
    exp_q.push_back(4'd8); exp_err_q.push_back(1'b0); exp_lat_q.push_back(3);
    kick(1'b0, 4'd8, 1'b0);
    wait_done(1'b0, -1, -1, r, e, lat, bc, to);
    er = exp_q.pop_front(); ee = exp_err_q.pop_front(); el = exp_lat_q.pop_front();
    checks++; if (to || r !== er || e !== ee) $display("FAIL t8_result got=%0d/%b exp=%0d/%b", r, e, er, ee); else passes++;
    checks++; if (lat != el) $display("FAIL t8_latency got=%0d exp=%0d", lat, el); else passes++;
    checks++; if (bc != 2 || b1.busy !== 1'b0) $display("FAIL t8_busy_window got=%0d,%b exp=2,0", bc, b1.busy); else passes++;
    @(negedge clk);
    checks++; if (b1.done !== 1'b0) $display("FAIL t8_done_pulse got=%b exp=0", b1.done); else passes++;
  endtask

  task automatic test_bad_flags();
    logic [W-1:0] r, er; logic e, ee; int lat, el, bc; bit to;
    exp_q.push_back(4'd8); exp_err_q.push_back(1'b1); exp_lat_q.push_back(3);
    kick(1'b0, 4'd5, 1'b1);
    wait_done(1'b0, -1, -1, r, e, lat, bc, to);
    er = exp_q.pop_front(); ee = exp_err_q.pop_front(); el = exp_lat_q.pop_front();
    checks++; if (to || r !== er) $display("FAIL bad_result got=%0d exp=%0d", r, er); else passes++;
    checks++; if (e !== ee) $display("FAIL bad_err got=%b exp=%b", e, ee); else passes++;
    checks++; if (lat != el) $display("FAIL bad_latency got=%0d exp=%0d", lat, el); else passes++;
    @(negedge clk);
    checks++; if (b1.err !== 1'b1) $display("FAIL bad_err_held got=%b exp=1", b1.err); else passes++;
    bad1 = 1'b0;
    exp_q.push_back(4'd5); exp_err_q.push_back(1'b0); exp_lat_q.push_back(1 + n_evals(4'd5) * 2);
    kick(1'b0, 4'd5, 1'b0);
    checks++; if (b1.err !== 1'b0) $display("FAIL bad_err_cleared got=%b exp=0", b1.err); else passes++;
    wait_done(1'b0, -1, -1, r, e, lat, bc, to);
    er = exp_q.pop_front(); ee = exp_err_q.pop_front(); el = exp_lat_q.pop_front();
    checks++; if (to || r !== er || e !== ee || lat != el) $display("FAIL bad_recover got=%0d/%b/%0d exp=%0d/%b/%0d", r, e, lat, er, ee, el); else passes++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] r, er; logic e, ee; int lat, el, bc; bit to;
    el = 1 + n_evals(4'd6) * 2;
    exp_q.push_back(4'd6); exp_err_q.push_back(1'b0); exp_lat_q.push_back(el);
    kick(1'b0, 4'd6, 1'b0);
    // Re-pulse start mid-search and again during the done cycle.
    wait_done(1'b0, 3, el, r, e, lat, bc, to);
    er = exp_q.pop_front(); ee = exp_err_q.pop_front(); el = exp_lat_q.pop_front();
    checks++; if (to || r !== er || e !== ee) $display("FAIL b2b_result got=%0d/%b exp=%0d/%b", r, e, er, ee); else passes++;
    checks++; if (lat != el) $display("FAIL b2b_latency got=%0d exp=%0d", lat, el); else passes++;
    @(negedge clk);
    start1 = 1'b0;
    checks++; if (b1.busy !== 1'b0 || dbg1 !== 2'd0) $display("FAIL b2b_idle got=%b/%0d exp=0/0", b1.busy, dbg1); else passes++;
    exp_q.push_back(4'd13); exp_err_q.push_back(1'b0); exp_lat_q.push_back(1 + n_evals(4'd13) * 2);
    kick(1'b0, 4'd13, 1'b0);
    wait_done(1'b0, -1, -1, r, e, lat, bc, to);
    er = exp_q.pop_front(); ee = exp_err_q.pop_front(); el = exp_lat_q.pop_front();
    checks++; if (to || r !== er || e !== ee || lat != el) $display("FAIL b2b_second got=%0d/%b/%0d exp=%0d/%b/%0d", r, e, lat, er, ee, el); else passes++;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] r, er; logic e, ee; int lat, el, bc, dcnt; bit to;
    kick(1'b0, 4'd9, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (b1.guess !== 4'd0 || b1.busy !== 1'b0 || b1.done !== 1'b0) $display("FAIL rst_abort got=%0d/%b/%b exp=0/0/0", b1.guess, b1.busy, b1.done); else passes++;
    rst_n = 1'b1;
    dcnt = 0;
    repeat (12) begin @(negedge clk); if (b1.done) dcnt++; end
    checks++; if (dcnt != 0) $display("FAIL rst_no_done got=%0d exp=0", dcnt); else passes++;
    exp_q.push_back(4'd15); exp_err_q.push_back(1'b0); exp_lat_q.push_back(1 + n_evals(4'd15) * 2);
    kick(1'b0, 4'd15, 1'b0);
    wait_done(1'b0, -1, -1, r, e, lat, bc, to);
    er = exp_q.pop_front(); ee = exp_err_q.pop_front(); el = exp_lat_q.pop_front();
    checks++; if (to || r !== er || e !== ee || lat != el) $display("FAIL rst_then_15 got=%0d/%b/%0d exp=%0d/%b/%0d", r, e, lat, er, ee, el); else passes++;
  endtask

  task automatic test_sweep_settle3();
    logic [W-1:0] r, er; logic e, ee; int lat, el, bc; bit to;
    logic [W-1:0] t;
    for (int i = 0; i < 16; i++) begin
      t = W'(i);
      exp_q.push_back(t); exp_err_q.push_back(1'b0); exp_lat_q.push_back(1 + n_evals(t) * 4);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      kick(1'b1, t, 1'b0);
      wait_done(1'b1, -1, -1, r, e, lat, bc, to);
      er = exp_q.pop_front(); ee = exp_err_q.pop_front(); el = exp_lat_q.pop_front();
      checks++;
      if (to || r !== er || e !== ee || lat != el)
        $display("FAIL sweep_t%0d got=%0d/%b/%0d exp=%0d/%b/%0d", i, r, e, lat, er, ee, el);
      else passes++;
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_target11();
    test_target0();
    test_target8();
    test_bad_flags();
    test_back_to_back();
    test_reset_mid();
    test_sweep_settle3();
    if (exp_q.size() != 0) begin
      checks++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
